// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arbiter_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default data memory size in bytes
    localparam int unsigned MEM_BYTES_DEF = 64;

    // Highest byte address at which a full doubleword still fits in the default memory
    localparam int unsigned LAST_ADDR_DEF = MEM_BYTES_DEF - 8;

    // Highest legal doubleword start address for a memory of the given size
    function automatic int unsigned last_legal_addr(input int unsigned mem_bytes);
        return mem_bytes - 32'd8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick, combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the master not served last wins
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data memory arbiter and access sequencer
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Any doubleword starting above this address would run past the end of memory
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_legal_addr(MEM_BYTES));

    state_t            state;
    logic              last_q;     // master served most recently (1 = m1)
    logic              owner_q;    // master owning the access in flight
    logic              we_q;       // access in flight is a write
    logic [1:0]        arb_gnt;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    rr_arb2 u_rr_arb2 (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Grants are only offered while the sequencer is idle; requests otherwise wait
    assign m0_gnt = (state == ST_IDLE) && arb_gnt[0];
    assign m1_gnt = (state == ST_IDLE) && arb_gnt[1];

    // Winner's request fields, muxed for latching at the grant edge
    assign win       = arb_gnt[1];
    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
    assign sel_err   = (sel_addr > LAST_ADDR);

    // Sequencer: grant/latch in IDLE, one memory cycle in ACCESS, completion pulse in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            m0_done   <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_done   <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_gnt || m1_gnt) begin
                        last_q  <= win;
                        owner_q <= win;
                        we_q    <= sel_we;
                        if (sel_err) begin
                            // Out-of-range: answer straight away, memory untouched
                            if (win) begin
                                m1_done <= 1'b1;
                                m1_err  <= 1'b1;
                            end else begin
                                m0_done <= 1'b1;
                                m0_err  <= 1'b1;
                            end
                            state <= ST_RESP;
                        end else begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_read  <= !sel_we;
                            mem_write <= sel_we;
                            state     <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    // Memory performs the write / presents read data on this edge
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (owner_q) begin
                        m1_done  <= 1'b1;
                        m1_rdata <= we_q ? '0 : mem_rdata;
                    end else begin
                        m0_done  <= 1'b1;
                        m0_rdata <= we_q ? '0 : mem_rdata;
                    end
                    state <= ST_RESP;
                end

                ST_RESP: begin
                    m0_done  <= 1'b0;
                    m0_rdata <= '0;
                    m0_err   <= 1'b0;
                    m1_done  <= 1'b0;
                    m1_rdata <= '0;
                    m1_err   <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
    logic [63:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
    logic [63:0] m1_addr, m1_wdata, m1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(64)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: 64 bytes, little-endian, comb read, posedge write
    logic [7:0] mem [0:63];
    logic       mem_load;

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 64'd56)
            for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr[5:0]) + i];
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[8]  <= 8'h05;
            mem[16] <= 8'h04;
            mem[40] <= 8'h08;
            mem[63] <= 8'h9A;
        end else if (mem_write && mem_addr <= 64'd56) begin
            for (int i = 0; i < 8; i++) mem[int'(mem_addr[5:0]) + i] <= mem_wdata[8*i +: 8];
        end
    end

    int total = 0;
    int bad = 0;
    int quiet_bad = 0;
    int done_cnt = 0;

    typedef struct {
        int          m;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t sb[$];
    int   gl_m[$];
    int   gl_c[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic drive(input int m, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        if (m == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Raise a request, hold it until granted, queue the expected response, release
    task automatic issue(input int m, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        drive(m, 1'b1, w, a, d);
        #1;
        n = 0;
        while (!(m == 0 ? m0_gnt : m1_gnt)) begin
            if (n == 40) begin
                fail_now(m == 0 ? "gnt_timeout_m0" : "gnt_timeout_m1");
                drive(m, 1'b0, 1'b0, 64'd0, 64'd0);
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        e = '{m, w, a, d, exp_rdata, exp_err, cyc};
        sb.push_back(e);
        gl_m.push_back(m);
        gl_c.push_back(cyc);
        @(negedge clk);
        drive(m, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: memory strobes and completion pulses checked against the scoreboard
    exp_t me;
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_gnt && m1_gnt) quiet_bad++;
            if (mem_read || mem_write) begin
                if (sb.size() == 0) begin
                    fail_now("strobe_unexpected");
                end else begin
                    me = sb[0];
                    chk("mem_addr", mem_addr, me.addr);
                    chk("mem_write", 64'(mem_write), 64'(me.we));
                    chk("mem_read", 64'(mem_read), 64'(!me.we));
                    chk("mem_touch_on_err", 64'(me.err), 64'd0);
                    chk("access_cycle", 64'(cyc), 64'(me.gcyc + 1));
                    if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
                end
            end else if (mem_addr != 64'd0 || mem_wdata != 64'd0) begin
                quiet_bad++;
            end
            if (m0_done || m1_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    me = sb.pop_front();
                    chk("done_owner", {62'd0, m1_done, m0_done}, me.m == 1 ? 64'd2 : 64'd1);
                    chk("rdata", me.m == 1 ? m1_rdata : m0_rdata, me.rdata);
                    chk("err", 64'(me.m == 1 ? m1_err : m0_err), 64'(me.err));
                    chk("done_latency", 64'(cyc - me.gcyc), me.err ? 64'd1 : 64'd2);
                    chk("other_master_quiet",
                        me.m == 1 ? (m0_rdata | 64'(m0_err)) : (m1_rdata | 64'(m1_err)), 64'd0);
                end
            end else if (m0_rdata != 64'd0 || m1_rdata != 64'd0 || m0_err || m1_err) begin
                quiet_bad++;
            end
        end
    end

    typedef struct {
        int          m;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_gnt"}, 64'(m0_gnt), 64'd0);
        chk({tag, "_m0_done"}, 64'(m0_done), 64'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 64'd0);
        chk({tag, "_m0_err"}, 64'(m0_err), 64'd0);
        chk({tag, "_m1_gnt"}, 64'(m1_gnt), 64'd0);
        chk({tag, "_m1_done"}, 64'(m1_done), 64'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 64'd0);
        chk({tag, "_m1_err"}, 64'(m1_err), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int dc;
        int dcnt;

        vecs[0]  = '{0, 1'b1, 64'd0,  64'h1122334455667788, 64'h0, 1'b0};
        vecs[1]  = '{0, 1'b0, 64'd0,  64'h0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1, 1'b0, 64'd8,  64'h0, 64'h5, 1'b0};
        vecs[3]  = '{0, 1'b0, 64'd40, 64'h0, 64'h8, 1'b0};
        vecs[4]  = '{1, 1'b0, 64'd57, 64'h0, 64'h0, 1'b1};
        vecs[5]  = '{0, 1'b0, 64'd56, 64'h0, 64'h9A00000000000000, 1'b0};
        vecs[6]  = '{0, 1'b0, 64'd4,  64'h0, 64'h0000000511223344, 1'b0};
        vecs[7]  = '{1, 1'b1, 64'd32, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0};
        vecs[8]  = '{0, 1'b0, 64'd32, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[9]  = '{0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h5555AAAA5555AAAA, 64'h0, 1'b1};
        vecs[10] = '{0, 1'b0, 64'd7,  64'h0, 64'h0000000000000511, 1'b0};
        vecs[11] = '{1, 1'b0, 64'd64, 64'h0, 64'h0, 1'b1};

        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b1;
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        mem_load = 1'b0;
        reset = 1'b0;

        // Sequential accesses from the vector table
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err);
            drain();
        end
        chk("boundary_last_legal", 64'(vecs[5].addr > 64'(LAST_ADDR_DEF)), 64'd0);

        // Both masters requesting together and holding: m0, m1, m0, three cycles apart
        k0 = gl_m.size();
        fork
            begin
                issue(0, 1'b0, 64'd8, 64'h0, 64'h5, 1'b0);
                issue(0, 1'b0, 64'd40, 64'h0, 64'h8, 1'b0);
            end
            issue(1, 1'b0, 64'd0, 64'h0, 64'h1122334455667788, 1'b0);
        join
        drain();
        chk("tie_grant_count", 64'(gl_m.size() - k0), 64'd3);
        if (gl_m.size() >= k0 + 3) begin
            chk("tie_order_0", 64'(gl_m[k0]), 64'd0);
            chk("tie_order_1", 64'(gl_m[k0+1]), 64'd1);
            chk("tie_order_2", 64'(gl_m[k0+2]), 64'd0);
            chk("tie_spacing_01", 64'(gl_c[k0+1] - gl_c[k0]), 64'd3);
            chk("tie_spacing_12", 64'(gl_c[k0+2] - gl_c[k0+1]), 64'd3);
        end

        // m1 write arriving while an m0 read is in RESP is granted on the next IDLE cycle
        dc = -100;
        fork
            issue(0, 1'b0, 64'd40, 64'h0, 64'h8, 1'b0);
            begin
                int n = 0;
                while (!m0_done && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                dc = cyc;
                issue(1, 1'b1, 64'd24, 64'h0123456789ABCDEF, 64'h0, 1'b0);
            end
        join
        drain();
        chk("resp_wait_master", 64'(gl_m[$]), 64'd1);
        chk("resp_wait_gnt_cycle", 64'(gl_c[$]), 64'(dc + 1));
        issue(0, 1'b0, 64'd24, 64'h0, 64'h0123456789ABCDEF, 1'b0);
        drain();

        // Reset during the ACCESS cycle of a write: nothing written, no done pulse
        issue(0, 1'b1, 64'd16, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0);
        chk("midop_in_access", 64'(mem_write), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("midop_reset");
        sb.delete();
        dcnt = done_cnt;
        repeat (2) @(negedge clk);
        chk("midop_byte16", 64'(mem[16]), 64'h4);
        chk("midop_byte17", 64'(mem[17]), 64'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midop_no_done", 64'(done_cnt), 64'(dcnt));

        issue(1, 1'b0, 64'd8, 64'h0, 64'h5, 1'b0);
        drain();
        issue(0, 1'b0, 64'd16, 64'h0, 64'h4, 1'b0);
        drain();

        chk("quiet_violations", 64'(quiet_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
